// File: rtl/ir_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ir_tx_arbiter: round-robin share of one NEC IR transmitter, 4 requesters |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ir_tx_arbiter #(
  parameter int FRAME_CYCLES = 6800000,
  parameter int GAP_CYCLES   = 4000000,
  parameter int CNT_W        = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] addr_in,
  input  logic [31:0] cmd_in,
  input  logic        abort,
  output logic [3:0]  ack,
  output logic [3:0]  done,
  output logic        aborted,
  output logic [1:0]  owner,
  output logic        busy,
  output logic        ir_en,
  output logic [7:0]  addr,
  output logic [7:0]  cmd
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_tx   = 2'd1;
  localparam logic [1:0] c_st_gap  = 2'd2;

  localparam logic [CNT_W-1:0] c_frame_last = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_gap_last   = CNT_W'(GAP_CYCLES - 1);

  logic [1:0]       state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [1:0]       rr_ptr_q,  rr_ptr_d;
  logic [1:0]       owner_q,   owner_d;
  logic [7:0]       addr_q,    addr_d;
  logic [7:0]       cmd_q,     cmd_d;
  logic             ir_en_q,   ir_en_d;
  logic             busy_q,    busy_d;
  logic [3:0]       ack_q,     ack_d;
  logic [3:0]       done_q,    done_d;
  logic             aborted_q, aborted_d;

  logic       w_grant;
  logic       w_cnt_zero;
  logic [1:0] w_win_idx;

  assign w_grant    = |req;
  assign w_cnt_zero = (cnt_q == '0);

  // Scan downward so the offset closest to rr_ptr is the last (winning) write.
  always_comb begin
    w_win_idx = rr_ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (req[rr_ptr_q + 2'(k)]) begin
        w_win_idx = rr_ptr_q + 2'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= c_st_idle;
      cnt_q     <= '0;
      rr_ptr_q  <= 2'd0;
      owner_q   <= 2'd0;
      addr_q    <= 8'd0;
      cmd_q     <= 8'd0;
      ir_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      ack_q     <= 4'd0;
      done_q    <= 4'd0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_ptr_q  <= rr_ptr_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      cmd_q     <= cmd_d;
      ir_en_q   <= ir_en_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      c_st_idle: begin
        if (w_grant) begin
          state_d  = c_st_tx;
          cnt_d    = c_frame_last;
          rr_ptr_d = w_win_idx + 2'd1;
        end
      end
      c_st_tx: begin
        // abort outranks the natural end of the frame
        if (abort || w_cnt_zero) begin
          state_d = c_st_gap;
          cnt_d   = c_gap_last;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      c_st_gap: begin
        if (w_cnt_zero) begin
          state_d = c_st_idle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = c_st_idle;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    owner_d   = owner_q;
    addr_d    = addr_q;
    cmd_d     = cmd_q;
    ir_en_d   = ir_en_q;
    busy_d    = busy_q;
    ack_d     = 4'd0;
    done_d    = 4'd0;
    aborted_d = 1'b0;
    case (state_q)
      c_st_idle: begin
        if (w_grant) begin
          owner_d           = w_win_idx;
          addr_d            = addr_in[{w_win_idx, 3'b000} +: 8];
          cmd_d             = cmd_in[{w_win_idx, 3'b000} +: 8];
          ack_d[w_win_idx]  = 1'b1;
          ir_en_d           = 1'b1;
          busy_d            = 1'b1;
        end
      end
      c_st_tx: begin
        if (abort) begin
          ir_en_d   = 1'b0;
          aborted_d = 1'b1;
        end else if (w_cnt_zero) begin
          ir_en_d         = 1'b0;
          done_d[owner_q] = 1'b1;
        end
      end
      c_st_gap: begin
        if (w_cnt_zero) begin
          busy_d = 1'b0;
        end
      end
      default: begin
        ir_en_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign ack     = ack_q;
  assign done    = done_q;
  assign aborted = aborted_q;
  assign owner   = owner_q;
  assign busy    = busy_q;
  assign ir_en   = ir_en_q;
  assign addr    = addr_q;
  assign cmd     = cmd_q;

endmodule
`default_nettype wire

// File: tb/tb_ir_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ir_tx_arbiter: directed scenarios plus randomized run vs. a model     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ir_tx_arbiter;
  localparam int F = 10;
  localparam int G = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] addr_in, cmd_in;
  logic        abort;
  logic [3:0]  ack, done;
  logic        aborted, busy, ir_en;
  logic [1:0]  owner;
  logic [7:0]  addr, cmd;

  int n_chk  = 0;
  int n_pass = 0;

  ir_tx_arbiter #(.FRAME_CYCLES(F), .GAP_CYCLES(G), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .addr_in(addr_in), .cmd_in(cmd_in),
    .abort(abort), .ack(ack), .done(done), .aborted(aborted), .owner(owner),
    .busy(busy), .ir_en(ir_en), .addr(addr), .cmd(cmd)
  );

  always #5 clk = ~clk;

  function automatic int pick(logic [3:0] m, int p);
    for (int k = 0; k < 4; k++) if (m[(p + k) % 4]) return (p + k) % 4;
    return 0;
  endfunction

  task automatic do_reset();
    rst = 1'b1; req = 4'd0; abort = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'hF; abort = 1'b1; addr_in = $urandom; cmd_in = $urandom;
    repeat (2) @(negedge clk);
    n_chk++; if (ir_en !== 1'b0) $display("FAIL rst_ir_en: got %b want 0", ir_en); else n_pass++;
    n_chk++; if (addr !== 8'd0) $display("FAIL rst_addr: got %h want 00", addr); else n_pass++;
    n_chk++; if (cmd !== 8'd0) $display("FAIL rst_cmd: got %h want 00", cmd); else n_pass++;
    n_chk++; if (ack !== 4'd0) $display("FAIL rst_ack: got %b want 0000", ack); else n_pass++;
    n_chk++; if (done !== 4'd0) $display("FAIL rst_done: got %b want 0000", done); else n_pass++;
    n_chk++; if (aborted !== 1'b0) $display("FAIL rst_aborted: got %b want 0", aborted); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (owner !== 2'd0) $display("FAIL rst_owner: got %0d want 0", owner); else n_pass++;
    req = 4'd0; abort = 1'b0; rst = 1'b0;
  endtask

  task automatic test_single_frame();
    int hi, b;
    do_reset();
    addr_in = $urandom; cmd_in = $urandom;
    addr_in[7:0] = 8'h10; cmd_in[7:0] = 8'hD8; req = 4'b0001;
    @(negedge clk);
    n_chk++; if (ack !== 4'b0001) $display("FAIL sf_ack: got %b want 0001", ack); else n_pass++;
    n_chk++; if (ir_en !== 1'b1) $display("FAIL sf_ir_en_rise: got %b want 1", ir_en); else n_pass++;
    n_chk++; if (addr !== 8'h10 || cmd !== 8'hD8)
      $display("FAIL sf_data: got %h/%h want 10/d8", addr, cmd); else n_pass++;
    req = 4'd0;
    hi = 1;
    for (int i = 0; i < 40 && ir_en === 1'b1; i++) begin
      addr_in = $urandom; cmd_in = $urandom;
      @(negedge clk);
      if (ir_en === 1'b1) begin
        hi++;
        n_chk++; if (addr !== 8'h10 || cmd !== 8'hD8 || ack !== 4'd0)
          $display("FAIL sf_hold: got %h/%h ack %b want 10/d8 ack 0000", addr, cmd, ack); else n_pass++;
      end
    end
    n_chk++; if (hi != F) $display("FAIL sf_ir_en_len: got %0d want %0d", hi, F); else n_pass++;
    n_chk++; if (done !== 4'b0001) $display("FAIL sf_done: got %b want 0001", done); else n_pass++;
    b = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); b++;
      if (busy !== 1'b1) break;
    end
    n_chk++; if (b != G) $display("FAIL sf_busy_fall: got %0d want %0d", b, G); else n_pass++;
  endtask

  task automatic test_round_robin();
    int t, last, idx;
    do_reset();
    addr_in = 32'hA3A2A1A0; cmd_in = 32'hC3C2C1C0; req = 4'hF;
    t = 0; last = 0;
    for (int g = 0; g < 5; g++) begin
      for (int w = 0; w < 40; w++) begin
        @(negedge clk); t++;
        if (ack !== 4'd0) break;
      end
      idx = g % 4;
      n_chk++; if (ack !== 4'(1 << idx)) $display("FAIL rr_order: got %b want %b", ack, 4'(1 << idx)); else n_pass++;
      n_chk++; if (ir_en !== 1'b1) $display("FAIL rr_ack_ir_en: got %b want 1", ir_en); else n_pass++;
      n_chk++; if (addr !== 8'hA0 + 8'(idx) || cmd !== 8'hC0 + 8'(idx))
        $display("FAIL rr_data: got %h/%h want %h/%h", addr, cmd, 8'hA0 + 8'(idx), 8'hC0 + 8'(idx)); else n_pass++;
      if (g > 0) begin
        n_chk++; if (t - last != F + G + 1)
          $display("FAIL rr_period: got %0d want %0d", t - last, F + G + 1); else n_pass++;
      end
      last = t;
    end
    req = 4'd0;
    for (int w = 0; w < 40 && busy === 1'b1; w++) @(negedge clk);
  endtask

  task automatic test_late_request();
    int t, td;
    do_reset();
    addr_in = $urandom; cmd_in = $urandom; req = 4'b0001;
    @(negedge clk);
    req = 4'd0; t = 0; td = 0;
    for (int w = 0; w < 40; w++) begin
      @(negedge clk); t++;
      if (done !== 4'd0) break;
    end
    td = t;
    req = 4'b0100;
    @(negedge clk); t++;
    req = 4'b0101;
    for (int w = 0; w < 40; w++) begin
      @(negedge clk); t++;
      if (ack !== 4'd0) break;
    end
    n_chk++; if (ack !== 4'b0100) $display("FAIL late_first: got %b want 0100", ack); else n_pass++;
    n_chk++; if (t - td != G + 1) $display("FAIL late_time: got %0d want %0d", t - td, G + 1); else n_pass++;
    req = 4'b0001;
    for (int w = 0; w < 40; w++) begin
      @(negedge clk);
      if (ack !== 4'd0) break;
    end
    n_chk++; if (ack !== 4'b0001) $display("FAIL late_second: got %b want 0001", ack); else n_pass++;
    req = 4'd0;
    for (int w = 0; w < 40 && busy === 1'b1; w++) @(negedge clk);
  endtask

  task automatic test_abort();
    int n_ab, n_dn, dt;
    do_reset();
    addr_in = $urandom; cmd_in = $urandom; req = 4'b0001;
    @(negedge clk);
    req = 4'd0;
    repeat (3) @(negedge clk);
    n_chk++; if (ir_en !== 1'b1) $display("FAIL ab_pre: got %b want 1", ir_en); else n_pass++;
    abort = 1'b1; req = 4'b0010;
    @(negedge clk);
    abort = 1'b0;
    n_chk++; if (ir_en !== 1'b0) $display("FAIL ab_ir_en: got %b want 0", ir_en); else n_pass++;
    n_chk++; if (aborted !== 1'b1 || done !== 4'd0)
      $display("FAIL ab_pulse: got aborted %b done %b want 1 0000", aborted, done); else n_pass++;
    n_ab = 0; n_dn = 0; dt = 0;
    for (int w = 0; w < 40; w++) begin
      abort = (w == 2);
      @(negedge clk); dt++;
      if (aborted === 1'b1) n_ab++;
      if (done !== 4'd0) n_dn++;
      if (ack !== 4'd0) break;
    end
    abort = 1'b0; req = 4'd0;
    n_chk++; if (dt != G + 1) $display("FAIL ab_regrant: got %0d want %0d", dt, G + 1); else n_pass++;
    n_chk++; if (ack !== 4'b0010) $display("FAIL ab_ack: got %b want 0010", ack); else n_pass++;
    n_chk++; if (n_ab != 0 || n_dn != 0)
      $display("FAIL ab_extra: got %0d aborted %0d done want 0 0", n_ab, n_dn); else n_pass++;
    for (int w = 0; w < 40 && busy === 1'b1; w++) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    addr_in = $urandom; cmd_in = $urandom; req = 4'b0100;
    @(negedge clk);
    req = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_chk++; if (ir_en !== 1'b0 || busy !== 1'b0 || owner !== 2'd0)
      $display("FAIL mr_state: got ir_en %b busy %b owner %0d want 0 0 0", ir_en, busy, owner); else n_pass++;
    n_chk++; if (done !== 4'd0 || aborted !== 1'b0)
      $display("FAIL mr_pulse: got done %b aborted %b want 0000 0", done, aborted); else n_pass++;
    rst = 1'b0; req = 4'b0010;
    @(negedge clk);
    n_chk++; if (ack !== 4'b0010 || ir_en !== 1'b1)
      $display("FAIL mr_regrant: got ack %b ir_en %b want 0010 1", ack, ir_en); else n_pass++;
    req = 4'd0;
    for (int w = 0; w < 40 && busy === 1'b1; w++) @(negedge clk);
  endtask

  task automatic test_withdraw();
    int n_ack, n_en;
    do_reset();
    addr_in = $urandom; cmd_in = $urandom; req = 4'b0001;
    @(negedge clk);
    req = 4'd0;
    repeat (2) @(negedge clk);
    req = 4'b1000;
    @(negedge clk);
    req = 4'd0;
    n_ack = 0; n_en = 0;
    for (int w = 0; w < 30; w++) begin
      @(negedge clk);
      if (ack !== 4'd0) n_ack++;
      if (w >= F + G && ir_en !== 1'b0) n_en++;
    end
    n_chk++; if (n_ack != 0) $display("FAIL wd_ack: got %0d acks want 0", n_ack); else n_pass++;
    n_chk++; if (n_en != 0) $display("FAIL wd_ir_en: got %0d high cycles want 0", n_en); else n_pass++;
  endtask

  // Model: frame/gap timing derived from the last grant, round-robin by pick().
  task automatic test_random(int cycles);
    logic [3:0]  pend, d_req, e_ack, e_done;
    logic [31:0] d_addr, d_cmd;
    logic        d_abort, ab, e_ab, e_en, e_busy;
    logic [7:0]  e_addr, e_cmd;
    int          c, last_ack, tx_end, ptr, e_owner, idx;
    do_reset();
    pend = 4'd0; c = 0; last_ack = -1; tx_end = 0; ptr = 0; e_owner = 0;
    ab = 1'b0; e_addr = 8'd0; e_cmd = 8'd0;
    for (int n = 0; n < cycles; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 11) == 0) pend[i] = 1'b1;
        else if (pend[i] && $urandom_range(0, 63) == 0) pend[i] = 1'b0;
      end
      d_req = pend; d_addr = $urandom; d_cmd = $urandom;
      d_abort = ($urandom_range(0, 39) == 0);
      req = d_req; addr_in = d_addr; cmd_in = d_cmd; abort = d_abort;
      @(negedge clk); c++;
      e_ack = 4'd0;
      if (last_ack >= 0 && d_abort && c - 1 >= last_ack && c - 1 < tx_end) begin
        tx_end = c; ab = 1'b1;
      end
      if ((last_ack < 0 || c >= tx_end + G + 1) && d_req != 4'd0) begin
        idx = pick(d_req, ptr);
        e_ack = 4'(1 << idx); last_ack = c; tx_end = c + F; ab = 1'b0;
        ptr = (idx + 1) % 4; e_owner = idx;
        e_addr = d_addr[8*idx +: 8]; e_cmd = d_cmd[8*idx +: 8];
        if ($urandom_range(0, 3) != 0) pend[idx] = 1'b0;
      end
      e_en   = (last_ack >= 0) && (c < tx_end);
      e_busy = (last_ack >= 0) && (c < tx_end + G);
      e_done = (last_ack >= 0 && c == tx_end && !ab) ? 4'(1 << e_owner) : 4'd0;
      e_ab   = (last_ack >= 0 && c == tx_end && ab);
      n_chk++; if (ack !== e_ack) $display("FAIL rnd_ack c%0d: got %b want %b", c, ack, e_ack); else n_pass++;
      n_chk++; if (ir_en !== e_en) $display("FAIL rnd_ir_en c%0d: got %b want %b", c, ir_en, e_en); else n_pass++;
      n_chk++; if (busy !== e_busy) $display("FAIL rnd_busy c%0d: got %b want %b", c, busy, e_busy); else n_pass++;
      n_chk++; if (done !== e_done) $display("FAIL rnd_done c%0d: got %b want %b", c, done, e_done); else n_pass++;
      n_chk++; if (aborted !== e_ab) $display("FAIL rnd_aborted c%0d: got %b want %b", c, aborted, e_ab); else n_pass++;
      n_chk++; if (owner !== 2'(e_owner)) $display("FAIL rnd_owner c%0d: got %0d want %0d", c, owner, e_owner); else n_pass++;
      n_chk++; if (addr !== e_addr || cmd !== e_cmd)
        $display("FAIL rnd_data c%0d: got %h/%h want %h/%h", c, addr, cmd, e_addr, e_cmd); else n_pass++;
    end
    req = 4'd0; abort = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 4'd0; addr_in = 32'd0; cmd_in = 32'd0; abort = 1'b0;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_late_request();
    test_abort();
    test_reset_mid_frame();
    test_withdraw();
    test_random(3000);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
